// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types and constants
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;
    localparam int UART_DATA_LEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;
endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchroniser for asynchronous inputs
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sync_2ff #(
    parameter int                WIDTH       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta     <= RESET_VALUE;
            sync_out <= RESET_VALUE;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end
endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 UART receiver, centre-sampled, single-cycle valid pulse
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 12_000_000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_uart_rx,
    output logic [UART_DATA_LEN-1:0] o_rx_data,
    output logic                     o_rx_valid,
    output logic                     o_rx_frame_err,
    output logic                     o_rx_busy
);
    localparam int CLOCKS_PER_BAUD = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BAUD       = CLOCKS_PER_BAUD / 2;
    localparam int CNT_W           = $clog2(CLOCKS_PER_BAUD) + 1;
    localparam int IDX_W           = $clog2(UART_DATA_LEN);

    rx_state_t                state;
    logic                     rx_s;
    logic                     rx_prev;
    logic [CNT_W-1:0]         bit_cnt;
    logic [CNT_W-1:0]         target;
    logic                     tick;
    logic [IDX_W-1:0]         bit_idx;
    logic [UART_DATA_LEN-1:0] shift;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .async_in (i_uart_rx),
        .sync_out (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rx_prev <= 1'b1;
        else          rx_prev <= rx_s;
    end

    // START waits half a bit to land on the start-bit centre; later bits wait a full bit
    always_comb begin
        target = CNT_W'(CLOCKS_PER_BAUD - 1);
        if (state == START) target = CNT_W'(HALF_BAUD - 1);
    end

    assign tick      = (bit_cnt == target);
    assign o_rx_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            o_rx_data      <= '0;
            o_rx_valid     <= 1'b0;
            o_rx_frame_err <= 1'b0;
        end else begin
            o_rx_valid     <= 1'b0;
            o_rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (rx_prev && !rx_s) state <= START;
                end
                START: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        shift   <= {rx_s, shift[UART_DATA_LEN-1:1]};
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_W'(UART_DATA_LEN - 1)) state <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                        // Only the first stop bit is checked; further stop bits are idle time
                        if (rx_s) begin
                            o_rx_data  <= shift;
                            o_rx_valid <= 1'b1;
                        end else begin
                            o_rx_frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : self-checking bench for uart_rx against a frame-level model
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;
    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_busy;

    uart_rx dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_uart_rx      (rx_line),
        .o_rx_data      (rx_data),
        .o_rx_valid     (rx_valid),
        .o_rx_frame_err (rx_frame_err),
        .o_rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int cyc = 0, n_valid = 0, n_err = 0, n_overlap = 0, valid_cyc = 0, start_cyc = 0;
    logic [7:0] model_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin n_valid++; valid_cyc = cyc; end
        if (rx_frame_err) n_err++;
        if (rx_valid && rx_frame_err) n_overlap++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Line-level frame: start bit, 8 data bits LSB first, first stop bit, extra stop bits high
    task automatic send_frame(input logic [7:0] d, input int per, input logic stop, input int nstop);
        logic line_bits[$];
        line_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) line_bits.push_back(d[i]);
        line_bits.push_back(stop);
        for (int i = 1; i < nstop; i++) line_bits.push_back(1'b1);
        @(negedge clk);
        start_cyc = cyc;
        foreach (line_bits[i]) begin
            rx_line = line_bits[i];
            repeat (per) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    // Model: a frame whose first stop bit is high yields its byte; otherwise a framing error
    task automatic frame_and_check(input string tag, input logic [7:0] d, input int per,
                                   input logic stop, input int nstop);
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(d, per, stop, nstop);
        if (stop) model_data = d;
        check({tag, " valid count"}, n_valid - v0, stop ? 1 : 0);
        check({tag, " frame_err count"}, n_err - e0, stop ? 0 : 1);
        check({tag, " data"}, rx_data, model_data);
    endtask

    typedef struct {
        logic [7:0] data;
        int         per;
        logic       stop;
        int         nstop;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int busy_cycles, e0, v0;

        vecs[0] = '{8'hA5, CPB,     1'b1, 1};
        vecs[1] = '{8'h00, CPB,     1'b1, 3};
        vecs[2] = '{8'hFF, CPB,     1'b1, 3};
        vecs[3] = '{8'h3C, CPB,     1'b1, 3};
        vecs[4] = '{8'h5A, CPB,     1'b0, 1};
        vecs[5] = '{8'h11, CPB,     1'b1, 1};
        vecs[6] = '{8'h96, CPB - 2, 1'b1, 1};
        vecs[7] = '{8'h96, CPB + 2, 1'b1, 1};

        repeat (3) @(negedge clk);
        check("reset data", rx_data, 8'h00);
        check("reset valid", rx_valid, 1'b0);
        check("reset frame_err", rx_frame_err, 1'b0);
        check("reset busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            frame_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].per,
                            vecs[i].stop, vecs[i].nstop);
            if (i == 0) check("valid latency", valid_cyc - start_cyc, 991);
        end

        // Glitch: short low pulse is rejected at the start-bit centre
        v0 = n_valid; e0 = n_err; busy_cycles = 0;
        @(negedge clk);
        rx_line = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (i == 20) rx_line = 1'b1;
            @(negedge clk);
            if (rx_busy) busy_cycles++;
        end
        check("glitch busy cycles", busy_cycles, 52);
        check("glitch no valid", n_valid - v0, 0);
        check("glitch no frame_err", n_err - e0, 0);

        // Break: one framing error, no retrigger while the line stays low
        e0 = n_err;
        @(negedge clk);
        rx_line = 1'b0;
        repeat (1200) @(negedge clk);
        check("break frame_err", n_err - e0, 1);
        check("break idle", rx_busy, 1'b0);
        repeat (400) @(negedge clk);
        check("break no retrigger", n_err - e0, 1);
        check("break still idle", rx_busy, 1'b0);
        rx_line = 1'b1;
        repeat (30) @(negedge clk);
        frame_and_check("after break", 8'h4B, CPB, 1'b1, 2);

        // Reset in the middle of data bit 4 of 8'hC3
        begin
            logic [7:0] c3;
            c3 = 8'hC3;
            @(negedge clk);
            rx_line = 1'b0;
            repeat (CPB) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rx_line = c3[i];
                repeat (CPB) @(negedge clk);
            end
            rx_line = c3[4];
            repeat (50) @(negedge clk);
            check("mid-frame busy before reset", rx_busy, 1'b1);
            #2 rst_n = 1'b0;
            #1;
            check("mid-frame reset data", rx_data, 8'h00);
            check("mid-frame reset busy", rx_busy, 1'b0);
            check("mid-frame reset valid", rx_valid, 1'b0);
            check("mid-frame reset frame_err", rx_frame_err, 1'b0);
            model_data = 8'h00;
            rx_line = 1'b1;
            repeat (5) @(negedge clk);
            rst_n = 1'b1;
            repeat (20) @(negedge clk);
            frame_and_check("after reset", 8'h7E, CPB, 1'b1, 1);
        end

        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            frame_and_check($sformatf("rand%0d", i), d, 102 + int'($urandom_range(0, 4)),
                            ($urandom_range(0, 3) != 0), 1 + int'($urandom_range(0, 2)));
        end

        repeat (20) @(negedge clk);
        check("valid/frame_err overlap", n_overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
